// File: rtl/branch_predict_unit.sv
// Resolves RV32I conditional branches and predicts fetch-stage branches with a
// direct-mapped table of 2-bit saturating counters, plus flush and perf counters.
module branch_predict_unit #(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 16,
  parameter int         INDEX_LSB   = 2,
  parameter logic [1:0] CTR_INIT    = 2'b01,
  parameter int         CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [XLEN-1:0]  lookup_pc,
  output logic             pred_taken,
  input  logic             branchSignal,
  input  logic [XLEN-1:0]  res_pc,
  input  logic             pred_was_taken,
  input  logic             zf,
  input  logic             cf,
  input  logic             sf,
  input  logic             vf,
  input  logic [2:0]       funct3,
  output logic             PCSrc,
  output logic             mispredict,
  output logic             flush,
  input  logic             perf_clr,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] res_idx;
  logic             cond;
  logic             update_en;
  logic             unused_pc_bits;

  assign lookup_idx     = lookup_pc[INDEX_LSB +: IDX_W];
  assign res_idx        = res_pc[INDEX_LSB +: IDX_W];
  assign unused_pc_bits = ^{lookup_pc, res_pc};

  // No bypass: a same-cycle update becomes visible on the next cycle.
  assign pred_taken = bht[lookup_idx][1];

  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = zf;
      3'b001:  cond = ~zf;
      3'b100:  cond = sf ^ vf;
      3'b101:  cond = ~(sf ^ vf);
      3'b110:  cond = ~cf;
      3'b111:  cond = cf;
      default: cond = 1'b0;
    endcase
  end

  assign PCSrc      = cond & branchSignal;
  assign mispredict = branchSignal & (PCSrc != pred_was_taken);
  assign update_en  = ~stall & branchSignal;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= CTR_INIT;
      end
    end else if (update_en) begin
      if (PCSrc) begin
        if (bht[res_idx] != 2'b11) bht[res_idx] <= bht[res_idx] + 2'd1;
      end else begin
        if (bht[res_idx] != 2'b00) bht[res_idx] <= bht[res_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      flush <= 1'b0;
    end else begin
      flush <= mispredict & ~stall;
    end
  end

  // Counters saturate so long runs never wrap back to small values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      br_count <= '0;
      mp_count <= '0;
    end else if (perf_clr) begin
      br_count <= '0;
      mp_count <= '0;
    end else if (update_en) begin
      if (br_count != CNT_MAX) br_count <= br_count + CNT_ONE;
      if (mispredict && (mp_count != CNT_MAX)) mp_count <= mp_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: a reference model feeds a
// scoreboard queue of registered expectations checked one cycle later.
module tb_branch_predict_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic        branchSignal;
  logic [31:0] res_pc;
  logic        pred_was_taken;
  logic        zf, cf, sf, vf;
  logic [2:0]  funct3;
  logic        PCSrc;
  logic        mispredict;
  logic        flush;
  logic        perf_clr;
  logic [31:0] br_count;
  logic [31:0] mp_count;

  logic        pred4, pcsrc4, misp4, flush4;
  logic [3:0]  br4, mp4;

  branch_predict_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .lookup_pc(lookup_pc),
    .pred_taken(pred_taken), .branchSignal(branchSignal), .res_pc(res_pc),
    .pred_was_taken(pred_was_taken), .zf(zf), .cf(cf), .sf(sf), .vf(vf),
    .funct3(funct3), .PCSrc(PCSrc), .mispredict(mispredict), .flush(flush),
    .perf_clr(perf_clr), .br_count(br_count), .mp_count(mp_count)
  );

  branch_predict_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .lookup_pc(lookup_pc),
    .pred_taken(pred4), .branchSignal(branchSignal), .res_pc(res_pc),
    .pred_was_taken(pred_was_taken), .zf(zf), .cf(cf), .sf(sf), .vf(vf),
    .funct3(funct3), .PCSrc(pcsrc4), .mispredict(misp4), .flush(flush4),
    .perf_clr(perf_clr), .br_count(br4), .mp_count(mp4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic [63:0] br;
    logic [63:0] mp;
    logic [63:0] br4;
    logic [63:0] mp4;
  } exp_t;

  typedef struct {
    logic [2:0] f3;
    logic [3:0] fl;
    logic       bs;
    logic       exp_pcsrc;
  } vec_t;

  exp_t        sb[$];
  vec_t        tbl[$];
  int          tests = 0;
  int          fails = 0;
  logic [1:0]  m_bht [16];
  logic        m_flush;
  logic [63:0] m_br, m_mp, m_br4, m_mp4;
  bit          m_valid = 0;

  function automatic logic condRef(input logic [2:0] f3, input logic [3:0] fl);
    logic z, c, s, v;
    {z, c, s, v} = fl;
    case (f3)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return s != v;
      3'd5:    return s == v;
      3'd6:    return !c;
      3'd7:    return c;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] satInc(input logic [63:0] v, input logic [63:0] maxv);
    return (v == maxv) ? v : v + 64'd1;
  endfunction

  task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      check1("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    check1("flush",    {63'd0, flush}, {63'd0, e.flush});
    check1("br_count", {32'd0, br_count}, e.br);
    check1("mp_count", {32'd0, mp_count}, e.mp);
    check1("br4",      {60'd0, br4}, e.br4);
    check1("mp4",      {60'd0, mp4}, e.mp4);
  endtask

  task automatic applyStimulus(input logic r, input logic st, input logic bs,
                               input logic [31:0] lpc, input logic [31:0] rpc,
                               input logic pwt, input logic [2:0] f3,
                               input logic [3:0] fl, input logic clr);
    exp_t e;
    logic c, mp;
    int   li, ri;
    rst = r; stall = st; branchSignal = bs; lookup_pc = lpc; res_pc = rpc;
    pred_was_taken = pwt; funct3 = f3; {zf, cf, sf, vf} = fl; perf_clr = clr;
    #1;
    li = int'(lpc[5:2]);
    ri = int'(rpc[5:2]);
    c  = condRef(f3, fl) & bs;
    mp = bs & (c != pwt);
    check1("PCSrc", {63'd0, PCSrc}, {63'd0, c});
    check1("mispredict", {63'd0, mispredict}, {63'd0, mp});
    if (m_valid) check1("pred_taken", {63'd0, pred_taken}, {63'd0, m_bht[li][1]});
    if (!r) begin
      for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
      m_flush = 0; m_br = 0; m_mp = 0; m_br4 = 0; m_mp4 = 0;
      m_valid = 1;
    end else begin
      if (!st && bs) begin
        if (c && m_bht[ri] != 2'b11) m_bht[ri] = m_bht[ri] + 2'd1;
        else if (!c && m_bht[ri] != 2'b00) m_bht[ri] = m_bht[ri] - 2'd1;
      end
      m_flush = mp & !st;
      if (clr) begin
        m_br = 0; m_mp = 0; m_br4 = 0; m_mp4 = 0;
      end else if (!st && bs) begin
        m_br  = satInc(m_br, 64'hFFFF_FFFF);
        m_br4 = satInc(m_br4, 64'hF);
        if (mp) begin
          m_mp  = satInc(m_mp, 64'hFFFF_FFFF);
          m_mp4 = satInc(m_mp4, 64'hF);
        end
      end
    end
    e.flush = m_flush; e.br = m_br; e.mp = m_mp; e.br4 = m_br4; e.mp4 = m_mp4;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle(input logic [31:0] lpc);
    applyStimulus(1, 0, 0, lpc, 32'h0, 0, 3'd0, 4'h0, 0);
  endtask

  localparam logic [3:0] TAKEN_EQ = 4'b1000;
  localparam logic [3:0] NOT_EQ   = 4'b0000;

  initial begin
    rst = 0; stall = 0; branchSignal = 0; lookup_pc = 0; res_pc = 0;
    pred_was_taken = 0; funct3 = 0; {zf, cf, sf, vf} = 4'h0; perf_clr = 0;

    for (int f = 0; f < 8; f++) begin
      for (int fl = 0; fl < 16; fl++) begin
        vec_t v;
        v.f3 = 3'(f); v.fl = 4'(fl); v.bs = 1'b1;
        v.exp_pcsrc = condRef(3'(f), 4'(fl));
        tbl.push_back(v);
      end
      tbl.push_back('{f3: 3'(f), fl: 4'hF, bs: 1'b0, exp_pcsrc: 1'b0});
      tbl.push_back('{f3: 3'(f), fl: 4'h0, bs: 1'b0, exp_pcsrc: 1'b0});
    end

    applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 3'd0, 4'h0, 0);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 3'd0, 4'h0, 0);
    idle(32'h123);
    check1("reset_pred", {63'd0, pred_taken}, 64'd0);
    check1("reset_counts", {32'd0, br_count | mp_count}, 64'd0);

    // Stalled sweep: pure condition decoding, no state changes.
    foreach (tbl[k]) begin
      applyStimulus(1, 1, tbl[k].bs, 32'h0, 32'h0, 0, tbl[k].f3, tbl[k].fl, 0);
      check1($sformatf("tbl_pcsrc_f%0d_fl%0h_bs%0d", tbl[k].f3, tbl[k].fl, tbl[k].bs),
             {63'd0, PCSrc}, {63'd0, tbl[k].exp_pcsrc});
    end
    check1("sweep_br_count", {32'd0, br_count}, 64'd0);

    // Training BEQ taken at 0x40, prediction travels with the branch.
    applyStimulus(1, 0, 1, 32'h40, 32'h40, m_bht[0][1], 3'd0, TAKEN_EQ, 0);
    check1("train_flush1", {63'd0, flush}, 64'd1);
    check1("train_pred_after1", {63'd0, pred_taken}, 64'd1);
    applyStimulus(1, 0, 1, 32'h40, 32'h40, m_bht[0][1], 3'd0, TAKEN_EQ, 0);
    applyStimulus(1, 0, 1, 32'h40, 32'h40, m_bht[0][1], 3'd0, TAKEN_EQ, 0);
    check1("train_br", {32'd0, br_count}, 64'd3);
    check1("train_mp", {32'd0, mp_count}, 64'd1);

    // Saturate down (11 -> 00), then alias through 0x80.
    for (int n = 0; n < 5; n++)
      applyStimulus(1, 0, 1, 32'h40, 32'h40, m_bht[0][1], 3'd0, NOT_EQ, 0);
    idle(32'h40);
    check1("sat_down_pred", {63'd0, pred_taken}, 64'd0);
    applyStimulus(1, 0, 1, 32'h40, 32'h80, 0, 3'd0, TAKEN_EQ, 0);
    applyStimulus(1, 0, 1, 32'h40, 32'h80, 0, 3'd0, TAKEN_EQ, 0);
    check1("alias_pred", {63'd0, pred_taken}, 64'd1);

    // Mispredicting branch held under stall, then released once.
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1, 1, 1, 32'h44, 32'h44, 0, 3'd0, TAKEN_EQ, 0);
      check1("stall_flush", {63'd0, flush}, 64'd0);
    end
    applyStimulus(1, 0, 1, 32'h44, 32'h44, 0, 3'd0, TAKEN_EQ, 0);
    check1("release_flush", {63'd0, flush}, 64'd1);
    idle(32'h44);
    check1("release_flush_gone", {63'd0, flush}, 64'd0);
    check1("release_pred", {63'd0, pred_taken}, 64'd1);

    // Same-cycle lookup/update at 0x48 (counter 01).
    lookup_pc = 32'h48;
    #1;
    check1("same_cycle_before", {63'd0, pred_taken}, 64'd0);
    applyStimulus(1, 0, 1, 32'h48, 32'h48, 0, 3'd0, TAKEN_EQ, 0);
    check1("same_cycle_after", {63'd0, pred_taken}, 64'd1);

    // 20 mispredicting BNEs saturate the 4-bit counters.
    for (int n = 0; n < 20; n++)
      applyStimulus(1, 0, 1, 32'h0, 32'h4C, 0, 3'd1, NOT_EQ, 0);
    check1("sat4_br", {60'd0, br4}, 64'hF);
    check1("sat4_mp", {60'd0, mp4}, 64'hF);

    applyStimulus(1, 0, 1, 32'h0, 32'h4C, 0, 3'd1, NOT_EQ, 1);
    check1("clr_br", {32'd0, br_count}, 64'd0);
    check1("clr_mp4", {60'd0, mp4}, 64'd0);

    applyStimulus(1, 0, 1, 32'h0, 32'h4C, 0, 3'd1, NOT_EQ, 0);
    applyStimulus(0, 0, 1, 32'h0, 32'h40, 0, 3'd0, TAKEN_EQ, 0);
    check1("midreset_flush", {63'd0, flush}, 64'd0);
    check1("midreset_mp", {32'd0, mp_count}, 64'd0);
    for (int i = 0; i < 16; i++) begin
      lookup_pc = 32'(i * 4);
      #1;
      check1($sformatf("midreset_pred%0d", i), {63'd0, pred_taken}, 64'd0);
    end
    idle(32'h40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
